i2c_slave_mem: RTL and testbench

I2C_SLAVE_MEM -- requirements
Module: i2c_slave_mem

---
 rtl/i2c_slave_mem.sv | 262 ++++++++++++++++++++++++++
 tb/tb_i2c_slave_mem.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_slave_mem.sv
// i2c_slave_mem: I2C slave exposing a small byte-addressed register file.
//
// Protocol: START, {SLAVE_ADDR, R/W}, then for writes a memory-address byte
// followed by any number of data bytes; for reads, bytes stream out of
// mem[ptr] until the master NACKs. STOP ends the transaction.
//
// Configuration macro: I2C_SLAVE_AUTOINC_EN
//   defined   - ptr advances after every written byte and every ACKed read byte
//   undefined - ptr stays at the last memory-address byte received
//
// Ports:
//   clk      - system clock, at least 8x the SCL rate
//   rst      - synchronous active-high reset
//   scl      - I2C clock from the master
//   sda      - open-drain I2C data, driven only low or released
//   wr_valid - one-cycle pulse when a byte is committed to memory
//   wr_addr  - address of the committed byte
//   wr_data  - value of the committed byte
//   busy     - high from an address-matched START until STOP
module i2c_slave_mem #(
    parameter logic [6:0] SLAVE_ADDR = 7'h50,
    parameter int         MEM_AW     = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              scl,
    inout  wire               sda,
    output logic              wr_valid,
    output logic [MEM_AW-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic              busy
);
    localparam int MEM_DEPTH = 1 << MEM_AW;

    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        ADDR      = 4'd1,
        ADDR_ACK  = 4'd2,
        MADDR     = 4'd3,
        MADDR_ACK = 4'd4,
        WDATA     = 4'd5,
        WDATA_ACK = 4'd6,
        RDATA     = 4'd7,
        RDATA_ACK = 4'd8
    } state_t;

    logic              scl_meta_r, scl_sync_r, scl_prev_r;
    logic              sda_meta_r, sda_sync_r, sda_prev_r;
    state_t            state_r, state_n;
    logic [3:0]        bit_cnt_r, bit_cnt_n;
    logic [7:0]        shift_r, shift_n;
    logic [MEM_AW-1:0] ptr_r, ptr_n, ptr_adv_s;
    logic              sda_oe_r, sda_oe_n;
    logic              busy_r, busy_n;
    logic              rw_r, rw_n;
    logic              nack_r, nack_n;
    logic              wr_valid_r, wr_valid_n;
    logic [MEM_AW-1:0] wr_addr_r, wr_addr_n;
    logic [7:0]        wr_data_r, wr_data_n;
    logic              mem_we_s;
    logic [7:0]        mem_r [MEM_DEPTH];
    logic              scl_rise_s, scl_fall_s, start_s, stop_s, rx_last_s;
    logic [7:0]        rx_byte_s, rd_cur_s, rd_next_s;

    // Edges and bus conditions are taken from synchronized samples only.
    assign scl_rise_s = scl_sync_r & ~scl_prev_r;
    assign scl_fall_s = ~scl_sync_r & scl_prev_r;
    assign start_s    = scl_sync_r & scl_prev_r & sda_prev_r & ~sda_sync_r;
    assign stop_s     = scl_sync_r & scl_prev_r & ~sda_prev_r & sda_sync_r;
    assign rx_byte_s  = {shift_r[6:0], sda_sync_r};
    assign rx_last_s  = (bit_cnt_r == 4'd7);
    assign rd_cur_s   = mem_r[ptr_r];
    assign rd_next_s  = mem_r[ptr_adv_s];

`ifdef I2C_SLAVE_AUTOINC_EN
    assign ptr_adv_s = ptr_r + {{(MEM_AW-1){1'b0}}, 1'b1};
`else
    assign ptr_adv_s = ptr_r;
`endif

    // Open-drain: only ever pull low or release.
    assign sda      = sda_oe_r ? 1'b0 : 1'bz;
    assign wr_valid = wr_valid_r;
    assign wr_addr  = wr_addr_r;
    assign wr_data  = wr_data_r;
    assign busy     = busy_r;

    // Two-flop synchronizers plus one history flop for edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            {scl_meta_r, scl_sync_r, scl_prev_r} <= 3'b111;
            {sda_meta_r, sda_sync_r, sda_prev_r} <= 3'b111;
        end else begin
            scl_meta_r <= scl;
            scl_sync_r <= scl_meta_r;
            scl_prev_r <= scl_sync_r;
            sda_meta_r <= sda;
            sda_sync_r <= sda_meta_r;
            sda_prev_r <= sda_sync_r;
        end
    end

    // Register file; a write commits on the same clock as the wr_valid pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < MEM_DEPTH; i++) begin
                mem_r[i] <= 8'h00;
            end
        end else if (mem_we_s) begin
            mem_r[ptr_r] <= rx_byte_s;
        end
    end

    // FSM and datapath state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= IDLE;
            bit_cnt_r  <= 4'd0;
            shift_r    <= 8'h00;
            ptr_r      <= {MEM_AW{1'b0}};
            sda_oe_r   <= 1'b0;
            busy_r     <= 1'b0;
            rw_r       <= 1'b0;
            nack_r     <= 1'b0;
            wr_valid_r <= 1'b0;
            wr_addr_r  <= {MEM_AW{1'b0}};
            wr_data_r  <= 8'h00;
        end else begin
            state_r    <= state_n;
            bit_cnt_r  <= bit_cnt_n;
            shift_r    <= shift_n;
            ptr_r      <= ptr_n;
            sda_oe_r   <= sda_oe_n;
            busy_r     <= busy_n;
            rw_r       <= rw_n;
            nack_r     <= nack_n;
            wr_valid_r <= wr_valid_n;
            wr_addr_r  <= wr_addr_n;
            wr_data_r  <= wr_data_n;
        end
    end

    // Next-state logic. STOP outranks START, which outranks any scl edge.
    // In ACK states bit_cnt marks whether the ACK slot has been entered yet.
    always_comb begin
        state_n    = state_r;
        bit_cnt_n  = bit_cnt_r;
        shift_n    = shift_r;
        ptr_n      = ptr_r;
        sda_oe_n   = sda_oe_r;
        busy_n     = busy_r;
        rw_n       = rw_r;
        nack_n     = nack_r;
        wr_valid_n = 1'b0;
        wr_addr_n  = wr_addr_r;
        wr_data_n  = wr_data_r;
        mem_we_s   = 1'b0;
        if (stop_s) begin
            state_n   = IDLE;
            bit_cnt_n = 4'd0;
            sda_oe_n  = 1'b0;
            busy_n    = 1'b0;
        end else if (start_s) begin
            state_n   = ADDR;
            bit_cnt_n = 4'd0;
            sda_oe_n  = 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    sda_oe_n  = 1'b0;
                    bit_cnt_n = 4'd0;
                end
                ADDR, MADDR, WDATA: begin
                    if (scl_rise_s) begin
                        shift_n   = rx_byte_s;
                        bit_cnt_n = rx_last_s ? 4'd0 : bit_cnt_r + 4'd1;
                        if (!rx_last_s) begin
                            state_n = state_r;
                        end else if (state_r == ADDR) begin
                            if (rx_byte_s[7:1] == SLAVE_ADDR) begin
                                state_n = ADDR_ACK;
                                busy_n  = 1'b1;
                                rw_n    = rx_byte_s[0];
                            end else begin
                                state_n = IDLE;
                            end
                        end else if (state_r == MADDR) begin
                            ptr_n   = rx_byte_s[MEM_AW-1:0];
                            state_n = MADDR_ACK;
                        end else begin
                            mem_we_s   = 1'b1;
                            wr_valid_n = 1'b1;
                            wr_addr_n  = ptr_r;
                            wr_data_n  = rx_byte_s;
                            ptr_n      = ptr_adv_s;
                            state_n    = WDATA_ACK;
                        end
                    end else begin
                        shift_n = shift_r;
                    end
                end
                ADDR_ACK, MADDR_ACK, WDATA_ACK: begin
                    if (!scl_fall_s) begin
                        sda_oe_n = sda_oe_r;
                    end else if (bit_cnt_r == 4'd0) begin
                        sda_oe_n  = 1'b1;
                        bit_cnt_n = 4'd1;
                    end else begin
                        bit_cnt_n = 4'd0;
                        sda_oe_n  = 1'b0;
                        if (state_r == ADDR_ACK && rw_r) begin
                            state_n  = RDATA;
                            shift_n  = rd_cur_s;
                            sda_oe_n = ~rd_cur_s[7];
                        end else if (state_r == ADDR_ACK) begin
                            state_n = MADDR;
                        end else begin
                            state_n = WDATA;
                        end
                    end
                end
                RDATA: begin
                    if (scl_rise_s) begin
                        bit_cnt_n = bit_cnt_r + 4'd1;
                    end else if (!scl_fall_s) begin
                        bit_cnt_n = bit_cnt_r;
                    end else if (bit_cnt_r == 4'd8) begin
                        sda_oe_n  = 1'b0;
                        bit_cnt_n = 4'd0;
                        state_n   = RDATA_ACK;
                    end else begin
                        // Rotate rather than shift so every bit stays in use.
                        shift_n  = {shift_r[6:0], shift_r[7]};
                        sda_oe_n = ~shift_r[6];
                    end
                end
                RDATA_ACK: begin
                    if (scl_rise_s) begin
                        nack_n    = sda_sync_r;
                        bit_cnt_n = 4'd1;
                    end else if (!(scl_fall_s && bit_cnt_r == 4'd1)) begin
                        bit_cnt_n = bit_cnt_r;
                    end else if (nack_r) begin
                        state_n   = IDLE;
                        bit_cnt_n = 4'd0;
                    end else begin
                        ptr_n     = ptr_adv_s;
                        shift_n   = rd_next_s;
                        sda_oe_n  = ~rd_next_s[7];
                        bit_cnt_n = 4'd0;
                        state_n   = RDATA;
                    end
                end
                default: begin
                    state_n   = IDLE;
                    bit_cnt_n = 4'd0;
                    sda_oe_n  = 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_i2c_slave_mem.sv
// tb_i2c_slave_mem: randomized self-checking bench for i2c_slave_mem.
// A bit-banged I2C master drives the DUT; expected bytes and write events come
// from a transaction-level memory/pointer model kept in the bench.
module tb_i2c_slave_mem;
    localparam int Q = 6;   // clk cycles per quarter SCL period

    logic       clk = 1'b0;
    logic       rst;
    logic       scl;
    logic       m_sda;
    wire        sda_bus;
    logic       wr_valid;
    logic [3:0] wr_addr;
    logic [7:0] wr_data;
    logic       busy;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0]  mem_m [16];
    logic [3:0]  ptr_m;
    logic [11:0] exp_q[$];
    logic [11:0] got_q[$];
    logic [7:0]  wbuf [4];

    assign sda_bus = m_sda ? 1'bz : 1'b0;
    pullup (sda_bus);

    always #5 clk = ~clk;

    i2c_slave_mem #(.SLAVE_ADDR(7'h50), .MEM_AW(4)) dut (
        .clk(clk), .rst(rst), .scl(scl), .sda(sda_bus),
        .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy)
    );

    // Collect committed writes away from the active edge.
    always @(negedge clk) begin
        if (!rst && wr_valid) got_q.push_back({wr_addr, wr_data});
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model (transaction level) ----------------
    task automatic m_reset();
        for (int i = 0; i < 16; i++) mem_m[i] = 8'h00;
        ptr_m = 4'd0;
    endtask

    task automatic m_write(input logic [7:0] d);
        mem_m[ptr_m] = d;
        exp_q.push_back({ptr_m, d});
`ifdef I2C_SLAVE_AUTOINC_EN
        ptr_m = ptr_m + 4'd1;
`endif
    endtask

    task automatic m_read(input logic acked, output logic [7:0] d);
        d = mem_m[ptr_m];
`ifdef I2C_SLAVE_AUTOINC_EN
        if (acked) ptr_m = ptr_m + 4'd1;
`endif
    endtask

    task automatic compare_wr(input string tag);
        check({tag, "_wr_count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
            check({tag, "_wr_event"}, {20'd0, got_q[i]}, {20'd0, exp_q[i]});
        got_q.delete();
        exp_q.delete();
    endtask

    // ---------------- bit-banged master ----------------
    task automatic wait_q();
        repeat (Q) @(negedge clk);
    endtask

    task automatic bus_start();
        m_sda = 1'b1; wait_q(); scl = 1'b1; wait_q();
        m_sda = 1'b0; wait_q(); scl = 1'b0; wait_q();
    endtask

    task automatic bus_stop();
        m_sda = 1'b0; wait_q(); scl = 1'b1; wait_q();
        m_sda = 1'b1; wait_q();
    endtask

    task automatic write_bit(input logic b);
        m_sda = b; wait_q(); scl = 1'b1; wait_q(); wait_q(); scl = 1'b0; wait_q();
    endtask

    task automatic read_bit(output logic b);
        m_sda = 1'b1; wait_q(); scl = 1'b1; wait_q();
        b = sda_bus; wait_q(); scl = 1'b0; wait_q();
    endtask

    task automatic send_byte(input logic [7:0] b, output logic ack);
        for (int i = 7; i >= 0; i--) write_bit(b[i]);
        read_bit(ack);
    endtask

    task automatic recv_byte(output logic [7:0] d, input logic ack_bit);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            read_bit(b);
            d[i] = b;
        end
        write_bit(ack_bit);
    endtask

    // ---------------- transactions ----------------
    task automatic do_write(input logic [7:0] maddr, input int n);
        logic ack;
        bus_start();
        send_byte(8'hA0, ack); check("wr_addr_ack", ack, 1'b0);
        check("busy_after_match", busy, 1'b1);
        send_byte(maddr, ack); check("wr_maddr_ack", ack, 1'b0);
        ptr_m = maddr[3:0];
        for (int i = 0; i < n; i++) begin
            send_byte(wbuf[i], ack); check("wr_data_ack", ack, 1'b0);
            m_write(wbuf[i]);
        end
        bus_stop();
        check("busy_after_stop", busy, 1'b0);
        compare_wr("write");
    endtask

    task automatic do_read(input logic [7:0] maddr, input int n);
        logic ack;
        logic [7:0] d, e;
        bus_start();
        send_byte(8'hA0, ack); check("rd_addr_ack", ack, 1'b0);
        send_byte(maddr, ack); check("rd_maddr_ack", ack, 1'b0);
        ptr_m = maddr[3:0];
        bus_start();
        send_byte(8'hA1, ack); check("rd_addr1_ack", ack, 1'b0);
        for (int i = 0; i < n; i++) begin
            recv_byte(d, (i == n - 1));
            m_read(i != n - 1, e);
            check("rd_byte", d, e);
        end
        bus_stop();
        check("busy_after_read", busy, 1'b0);
        compare_wr("read");
    endtask

    initial begin
        logic ack;
        logic [7:0] d, e;
        rst = 1'b1; scl = 1'b1; m_sda = 1'b1;
        m_reset();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_wr_valid", wr_valid, 1'b0);
        check("rst_wr_addr", wr_addr, 4'd0);
        check("rst_wr_data", wr_data, 8'h00);
        check("rst_busy", busy, 1'b0);
        check("rst_sda_released", sda_bus, 1'b1);

        // Directed write and read-back at 3.
        wbuf[0] = 8'h11; wbuf[1] = 8'h22;
        do_write(8'h03, 2);
        do_read(8'h03, 2);

        // Wrong address: no ACK, not busy, later bytes ignored.
        bus_start();
        send_byte(8'hA2, ack); check("wrong_addr_nack", ack, 1'b1);
        check("wrong_addr_busy", busy, 1'b0);
        send_byte(8'h5A, ack); check("wrong_addr_data_nack", ack, 1'b1);
        bus_stop();
        compare_wr("wrong_addr");

        // Pointer wrap at the top of memory.
        wbuf[0] = 8'hAA; wbuf[1] = 8'hBB;
        do_write(8'h0F, 2);
        do_read(8'h0F, 1);
        do_read(8'h00, 1);

        // Abort a data byte after 4 bits; pointer and memory untouched.
        wbuf[0] = 8'h5A;
        do_write(8'h05, 1);
        bus_start();
        send_byte(8'hA0, ack); check("abort_addr_ack", ack, 1'b0);
        send_byte(8'h05, ack); check("abort_maddr_ack", ack, 1'b0);
        ptr_m = 4'd5;
        for (int i = 0; i < 4; i++) write_bit(i[0]);
        bus_stop();
        compare_wr("abort");
        bus_start();
        send_byte(8'hA1, ack); check("abort_rd_ack", ack, 1'b0);
        recv_byte(d, 1'b1);
        m_read(1'b0, e);
        check("abort_rd_byte", d, e);
        bus_stop();

        // Randomized write/read-back transactions.
        for (int it = 0; it < 6; it++) begin
            int n;
            logic [7:0] ma;
            ma = 8'($urandom_range(0, 255));
            n  = $urandom_range(1, 3);
            for (int i = 0; i < n; i++) wbuf[i] = 8'($urandom);
            do_write(ma, n);
            do_read(ma, n + 1);
        end

        // Reset while the slave is driving a 0 data bit.
        wbuf[0] = 8'h11;
        do_write(8'h03, 1);
        bus_start();
        send_byte(8'hA0, ack); check("rstt_addr_ack", ack, 1'b0);
        send_byte(8'h03, ack); check("rstt_maddr_ack", ack, 1'b0);
        bus_start();
        send_byte(8'hA1, ack); check("rstt_addr1_ack", ack, 1'b0);
        check("rstt_sda_driven_low", sda_bus, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rstt_sda_released", sda_bus, 1'b1);
        check("rstt_busy", busy, 1'b0);
        m_reset();
        bus_stop();
        do_read(8'h03, 1);
        compare_wr("reset");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
